conv_lbx_nline: RTL and testbench
=================================

# conv_lbx_nline

Parametrised vertical-window line buffer for the convolution pipeline. It accepts a raster pixel stream and, for every accepted pixel, emits one column of K vertically adjacent pixels: the current pixel plus the pixels at the same column index in the K-1 previous lines of the frame. The horizontal window stage downstream consumes these columns. Compared with the fixed single-line buffer, this block adds configurable depth, pixel width and maximum line length, frame-start handling, top-edge padding modes, input stall, and overflow detection.

## Interface
- W, 8: pixel width in bits.
- K, 3: window height in lines; K >= 2.
- MAX_COLS, 1024: maximum pixels per line; column counter width is clog2(MAX_COLS).
- PAD_MODE, 0: top-edge fill for rows not yet present in the frame; 0 = zero, 1 = replicate oldest valid row.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_vld_i  in  1  input pixel valid.
- pixel_dat_i  in  W  input pixel.
- pixel_sof_i  in  1  first pixel of a frame; qualified by pixel_vld_i.
- pixel_eol_i  in  1  last pixel of a line; qualified by pixel_vld_i.
- stall_i  in  1  blocks acceptance; upstream holds its beat while high.
- col_vld_o  out  1  output column valid, one-cycle pulse.
- col_dat_o  out  K*W  column; slice [W*i +: W] is the pixel i lines above the current one (i = 0 is current).
- col_eol_o  out  1  column is the last in its line.
- err_o  out  1  sticky line-overflow flag.

## Operation
- Accept when pixel_vld_i && !stall_i. No other input state changes occur.
- State:
  - col_q: column index, 0..MAX_COLS-1.
  - row_q: completed lines in the current frame, saturating at K-1.
  - K-1 line memories of depth MAX_COLS, each W bits.
  - Memory j (1..K-1) holds line "j above".
- Effective row and column on accept:
  - If sof: eff_col = 0 and eff_row = 0.
  - Otherwise: eff_col = col_q and eff_row = row_q.
- On accept, at address eff_col:
  - Read all memories, then write. Memory 1 receives pixel_dat_i and memory j receives the old memory j-1 value. This is a shift across lines, read-before-write.
- Column output:
  - Slot 0 = pixel_dat_i.
  - Slot i = old memory i value, if i <= eff_row.
  - If i > eff_row, slot i is padded:
    - PAD_MODE 0: zero.
    - PAD_MODE 1: the slot eff_row value. For eff_row = 0 this is the current pixel.
- Counter update on accept:
  - eol: col_q <= 0 and row_q <= min(eff_row+1, K-1).
  - Else, eff_col < MAX_COLS-1: col_q <= eff_col+1.
  - Else: col_q holds at MAX_COLS-1 and err_o <= 1.
  - A pixel with both sof and eol is a one-pixel line: row_q <= 1 afterwards.
- Line length is not checked against previous lines. Shorter or longer lines read whatever the memories hold. Only saturation at MAX_COLS raises err_o.
- Memory contents are never reset. Stale data is masked only by the row_q padding rule.

## Timing
- Latency: the column is registered and appears 1 cycle after the accept cycle, with col_vld_o = 1 for exactly that cycle.
- col_eol_o and col_dat_o are valid with col_vld_o. col_dat_o holds its last value otherwise.
- stall_i affects only acceptance. A column already scheduled still issues the next cycle.
- Throughput: one pixel per cycle.
- Reset values: col_vld_o = 0, col_eol_o = 0, col_dat_o = 0, err_o = 0, col_q = 0, row_q = 0.
- err_o clears only on rst.
- Reset mid-line or mid-frame: the next accepted pixel is treated as row 0, column 0 with full padding, whether or not sof is set.
- sof mid-line discards the partial line and row history.

## Test plan
- **Fill and steady state** (K=3, W=8, PAD_MODE 0):
  - Stimulus: three 4-pixel lines with values 0x10-0x13, 0x20-0x23, 0x30-0x33. sof on 0x10, eol on each line's last pixel.
  - Line 0 columns: {0,0,0x1c}.
  - Line 1, col 2: {0,0x12,0x22}.
  - Line 2, col 3: {0x13,0x23,0x33}, with col_eol_o = 1.
- **Replicate padding**:
  - Stimulus: same input with PAD_MODE 1.
  - Line 0, col 1: {0x11,0x11,0x11}.
  - Line 1, col 0: {0x10,0x10,0x20}.
- **Stall**:
  - Stimulus: hold pixel 0x21 with pixel_vld_i = 1 and stall_i = 1 for 3 cycles, then release.
  - Required: no col_vld_o during the stall, exactly one column for 0x21 after release, and no duplicate.
- **Overflow** (MAX_COLS = 8):
  - Stimulus: 10 pixels with no eol.
  - Required: err_o = 1 from the cycle after the 8th pixel. Pixels 9-10 overwrite address 7. err_o stays 1 after a later eol and sof.
- **New frame and reset mid-frame**:
  - Stimulus: after 5 lines, send sof with 0x50.
  - Required: column {0,0,0x50}.
  - Stimulus: assert rst mid-line 1, then send 0x60 without sof.
  - Required: column {0,0,0x60}, all outputs 0 during rst.
- **One-pixel lines**:
  - Stimulus: sof+eol 0xA0, then eol 0xA1, then eol 0xA2.
  - Required columns: {0,0,0xA0}, then {0,0xA0,0xA1}, then {0xA0,0xA1,0xA2}, each with col_eol_o = 1.

Source files
------------

// File: rtl/conv_lbx_nline_if.sv
// rtl/conv_lbx_nline_if.sv - pixel-in / column-out bus for the vertical line buffer
interface conv_lbx_nline_if #(
  parameter int W = 8,
  parameter int K = 3
);
  logic           pixel_vld_i;
  logic [W-1:0]   pixel_dat_i;
  logic           pixel_sof_i;
  logic           pixel_eol_i;
  logic           stall_i;
  logic           col_vld_o;
  logic [K*W-1:0] col_dat_o;
  logic           col_eol_o;
  logic           err_o;

  modport master (
    output pixel_vld_i, pixel_dat_i, pixel_sof_i, pixel_eol_i, stall_i,
    input  col_vld_o, col_dat_o, col_eol_o, err_o
  );

  modport slave (
    input  pixel_vld_i, pixel_dat_i, pixel_sof_i, pixel_eol_i, stall_i,
    output col_vld_o, col_dat_o, col_eol_o, err_o
  );
endinterface

// File: rtl/conv_lbx_nline.sv
// rtl/conv_lbx_nline.sv - K-line vertical window buffer with top-edge padding
module conv_lbx_nline #(
  parameter int W        = 8,
  parameter int K        = 3,
  parameter int MAX_COLS = 1024,
  parameter int PAD_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  conv_lbx_nline_if.slave bus
);

  localparam int CW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int RW = $clog2(K);
  localparam logic [CW-1:0] LAST_COL = CW'(MAX_COLS - 1);
  localparam logic [RW-1:0] TOP_ROW  = RW'(K - 1);

  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic           err_q;
  logic           vld_q;
  logic           eol_q;
  logic [K*W-1:0] dat_q;

  logic           accept;
  logic [CW-1:0]  eff_col;
  logic [RW-1:0]  eff_row;
  logic [W-1:0]   pad_pix;
  logic [K*W-1:0] col_next;

  // Line j above lives in mem[j]; contents are deliberately never reset,
  // stale entries are hidden by the row padding instead.
  logic [W-1:0] mem     [1:K-1][0:MAX_COLS-1];
  logic [W-1:0] old_pix [1:K-1];

  // Acceptance and the effective position; sof restarts at row 0, column 0.
  always_comb begin
    accept  = bus.pixel_vld_i && !bus.stall_i;
    eff_col = bus.pixel_sof_i ? '0 : col_q;
    eff_row = bus.pixel_sof_i ? '0 : row_q;
  end

  // Read every stored line at the current column before it is overwritten.
  always_comb begin
    for (int j = 1; j < K; j++) begin
      old_pix[j] = mem[j][eff_col];
    end
  end

  // Assemble the column, padding rows the frame has not produced yet.
  always_comb begin
    pad_pix = bus.pixel_dat_i;
    for (int j = 1; j < K; j++) begin
      if (int'(eff_row) == j) pad_pix = old_pix[j];
    end
    col_next          = '0;
    col_next[W-1:0]   = bus.pixel_dat_i;
    for (int i = 1; i < K; i++) begin
      if (i <= int'(eff_row)) begin
        col_next[W*i +: W] = old_pix[i];
      end else if (PAD_MODE == 1) begin
        col_next[W*i +: W] = pad_pix;
      end
    end
  end

  // Shift the column down one line: new pixel into line 1, line j-1 into line j.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[1][eff_col] <= bus.pixel_dat_i;
      for (int j = 2; j < K; j++) begin
        mem[j][eff_col] <= old_pix[j-1];
      end
    end
  end

  // Column / row position tracking and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (bus.pixel_eol_i) begin
        col_q <= '0;
        row_q <= (eff_row == TOP_ROW) ? TOP_ROW : eff_row + RW'(1);
      end else begin
        row_q <= eff_row;
        if (eff_col < LAST_COL) begin
          col_q <= eff_col + CW'(1);
        end else begin
          col_q <= LAST_COL;
          err_q <= 1'b1;
        end
      end
    end
  end

  // Registered column output; data holds between valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      eol_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        eol_q <= bus.pixel_eol_i;
        dat_q <= col_next;
      end
    end
  end

  assign bus.col_vld_o = vld_q;
  assign bus.col_eol_o = eol_q;
  assign bus.col_dat_o = dat_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_conv_lbx_nline.sv
// tb/tb_conv_lbx_nline.sv - randomized and directed bench for conv_lbx_nline
module tb_conv_lbx_nline;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int MC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         vld = 1'b0, sof = 1'b0, eol = 1'b0, stall = 1'b0;
  logic [W-1:0] dat = '0;

  conv_lbx_nline_if #(.W(W), .K(K)) bus0 ();
  conv_lbx_nline_if #(.W(W), .K(K)) bus1 ();

  assign bus0.pixel_vld_i = vld;
  assign bus0.pixel_dat_i = dat;
  assign bus0.pixel_sof_i = sof;
  assign bus0.pixel_eol_i = eol;
  assign bus0.stall_i     = stall;
  assign bus1.pixel_vld_i = vld;
  assign bus1.pixel_dat_i = dat;
  assign bus1.pixel_sof_i = sof;
  assign bus1.pixel_eol_i = eol;
  assign bus1.stall_i     = stall;

  conv_lbx_nline #(.W(W), .K(K), .MAX_COLS(MC), .PAD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  conv_lbx_nline #(.W(W), .K(K), .MAX_COLS(MC), .PAD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  int n_vec = 0;
  int n_err = 0;

  // Reference: per-column history of written pixels, newest first.
  logic [W-1:0]   hist [MC][$];
  int             m_col = 0;
  int             m_row = 0;
  bit             m_err = 0;
  bit             exp_vld = 0;
  bit             exp_eol = 0;
  logic [K*W-1:0] exp_dat0 = '0;
  logic [K*W-1:0] exp_dat1 = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycle(input bit v, input bit s, input bit e, input bit st, input logic [W-1:0] d);
    int           ec, er;
    logic [W-1:0] above [K];
    vld = v; sof = s; eol = e; stall = st; dat = d;
    exp_vld = v && !st;
    if (exp_vld) begin
      ec = s ? 0 : m_col;
      er = s ? 0 : m_row;
      above[0] = d;
      for (int i = 1; i < K; i++)
        above[i] = (i - 1 < hist[ec].size()) ? hist[ec][i-1] : '0;
      for (int i = 0; i < K; i++) begin
        exp_dat0[W*i +: W] = (i <= er) ? above[i] : '0;
        exp_dat1[W*i +: W] = (i <= er) ? above[i] : above[er];
      end
      hist[ec].push_front(d);
      if (hist[ec].size() > K - 1) void'(hist[ec].pop_back());
      exp_eol = e;
      if (e) begin
        m_col = 0;
        m_row = (er + 1 > K - 1) ? K - 1 : er + 1;
      end else begin
        m_row = er;
        if (ec < MC - 1) m_col = ec + 1;
        else begin
          m_col = MC - 1;
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("vld0", bus0.col_vld_o, exp_vld);
    check("vld1", bus1.col_vld_o, exp_vld);
    check("dat0", bus0.col_dat_o, exp_dat0);
    check("dat1", bus1.col_dat_o, exp_dat1);
    if (exp_vld) begin
      check("eol0", bus0.col_eol_o, exp_eol);
      check("eol1", bus1.col_eol_o, exp_eol);
    end
    check("err0", bus0.err_o, m_err);
    check("err1", bus1.err_o, m_err);
  endtask

  task automatic do_reset(input int n);
    rst = 1; vld = 0; sof = 0; eol = 0; stall = 0;
    m_col = 0; m_row = 0; m_err = 0;
    exp_vld = 0; exp_eol = 0; exp_dat0 = '0; exp_dat1 = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_vld", {bus0.col_vld_o, bus1.col_vld_o}, 0);
      check("rst_eol", {bus0.col_eol_o, bus1.col_eol_o}, 0);
      check("rst_err", {bus0.err_o, bus1.err_o}, 0);
      check("rst_dat0", bus0.col_dat_o, 0);
      check("rst_dat1", bus1.col_dat_o, 0);
    end
    rst = 0;
  endtask

  task automatic send(input bit s, input bit e, input logic [W-1:0] d);
    bit st;
    do begin
      st = ($urandom_range(0, 3) == 0);
      cycle(1, s, e, st, d);
    end while (st);
    if ($urandom_range(0, 4) == 0) cycle(0, 0, 0, 0, '0);
  endtask

  task automatic line4(input logic [W-1:0] base, input bit first);
    for (int c = 0; c < 4; c++) cycle(1, first && c == 0, c == 3, 0, base + W'(c));
  endtask

  initial begin
    do_reset(2);

    // fill and steady state, both padding modes side by side
    for (int c = 0; c < 4; c++) begin
      cycle(1, c == 0, c == 3, 0, 8'h10 + W'(c));
      check("fill_l0", bus0.col_dat_o, {16'h0, 8'h10 + W'(c)});
      if (c == 1) check("rep_l0c1", bus1.col_dat_o, 24'h111111);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1, 0, c == 3, 0, 8'h20 + W'(c));
      if (c == 0) check("rep_l1c0", bus1.col_dat_o, 24'h101020);
      if (c == 2) check("fill_l1c2", bus0.col_dat_o, 24'h001222);
    end
    for (int c = 0; c < 4; c++) cycle(1, 0, c == 3, 0, 8'h30 + W'(c));
    check("fill_l2c3", bus0.col_dat_o, 24'h132333);
    check("fill_l2c3_eol", bus0.col_eol_o, 1);

    // stall holding pixel 0x21
    line4(8'h10, 1);
    cycle(1, 0, 0, 0, 8'h20);
    repeat (3) cycle(1, 0, 0, 1, 8'h21);
    cycle(1, 0, 0, 0, 8'h21);
    check("stall_col", bus0.col_dat_o, 24'h001121);
    cycle(0, 0, 0, 0, 8'h21);
    cycle(1, 0, 0, 0, 8'h22);
    cycle(1, 0, 1, 0, 8'h23);

    // one-pixel lines
    cycle(1, 1, 1, 0, 8'hA0);
    check("one_a0", bus0.col_dat_o, 24'h0000A0);
    cycle(1, 0, 1, 0, 8'hA1);
    check("one_a1", bus0.col_dat_o, 24'h00A0A1);
    cycle(1, 0, 1, 0, 8'hA2);
    check("one_a2", bus0.col_dat_o, 24'hA0A1A2);
    check("one_a2_eol", bus0.col_eol_o, 1);

    // overflow: 10 pixels, no eol
    for (int p = 1; p <= 10; p++) begin
      cycle(1, p == 1, 0, 0, 8'hC0 + W'(p));
      if (p == 7) check("ovf_before", bus0.err_o, 0);
      if (p == 8) check("ovf_at8", bus0.err_o, 1);
    end
    cycle(1, 0, 1, 0, 8'hCF);
    cycle(1, 1, 0, 0, 8'hD0);
    check("ovf_sticky", bus0.err_o, 1);
    cycle(1, 0, 1, 0, 8'hD1);

    // new frame after five lines
    for (int l = 0; l < 5; l++) line4(8'h40 + W'(l * 4), l == 0);
    cycle(1, 1, 0, 0, 8'h50);
    check("sof_col0", bus0.col_dat_o, 24'h000050);
    check("sof_col1", bus1.col_dat_o, 24'h505050);
    cycle(1, 0, 0, 0, 8'h51);
    cycle(1, 0, 1, 0, 8'h52);
    cycle(1, 0, 0, 0, 8'h53);
    cycle(1, 0, 0, 0, 8'h54);

    // reset mid-line, then a pixel without sof
    do_reset(2);
    cycle(1, 0, 0, 0, 8'h60);
    check("rst_next0", bus0.col_dat_o, 24'h000060);
    check("rst_next1", bus1.col_dat_o, 24'h606060);
    cycle(1, 0, 1, 0, 8'h61);

    // randomized frames with random stalls and gaps
    for (int f = 0; f < 12; f++) begin
      int len, lines;
      len   = $urandom_range(1, MC);
      lines = $urandom_range(1, 6);
      for (int l = 0; l < lines; l++)
        for (int c = 0; c < len; c++)
          send(l == 0 && c == 0, c == len - 1, W'($urandom));
    end
    cycle(0, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
